// File: rtl/bus_region_decoder.sv
// bus_region_decoder: registered base/mask bus-cycle decoder for an 8086-style bus.
// Produces one-hot chip selects, per-region wait-state READY and single-cycle
// read/write strobes. Optional sticky unmapped-access flag under `UNMAPPED_ERR_EN`
// (adds ports err / err_clr).
module bus_region_decoder #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 20,
    parameter int WAIT_W      = 3,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {20'h40000, 20'h20000, 20'h00000, 20'h00000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
        {20'hE0000, 20'hE0000, 20'hE0000, 20'h000C0},
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT =
        {3'd2, 3'd1, 3'd0, 3'd0},
    parameter logic [NUM_REGIONS-1:0] REGION_IO = 4'b0001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      a,
    input  logic                   m_io,
    input  logic                   rd,
    input  logic                   wr,
    output logic [NUM_REGIONS-1:0] cs,
    output logic                   hit,
    output logic                   ready,
    output logic                   rd_stb,
    output logic                   wr_stb
`ifdef UNMAPPED_ERR_EN
    ,
    input  logic                   err_clr,
    output logic                   err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_REGIONS-1:0] r_cs, w_cs_nxt;
    logic                   r_hit, w_hit_nxt;
    logic                   r_wr, w_wr_nxt;
    logic [WAIT_W-1:0]      r_count, w_count_nxt;

    logic [NUM_REGIONS-1:0] w_match;
    logic [NUM_REGIONS-1:0] w_sel;
    logic [WAIT_W-1:0]      w_wait;
    logic                   w_found;
    logic                   w_req;

    assign w_req = rd | wr;

    // Raw per-region window match: masked address compare plus address-space check.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_match[i] = (((a ^ REGION_BASE[i*ADDR_W +: ADDR_W]) &
                           REGION_MASK[i*ADDR_W +: ADDR_W]) == '0) &&
                         (m_io == ~REGION_IO[i]);
        end
    end

    // Priority select: lowest matching index wins, keeping the select one-hot.
    always_comb begin
        w_sel   = '0;
        w_wait  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (w_match[i] && !w_found) begin
                w_sel[i] = 1'b1;
                w_wait   = REGION_WAIT[i*WAIT_W +: WAIT_W];
                w_found  = 1'b1;
            end
        end
    end

    // Next-state and Moore outputs; strobes/ready decode only from registered state
    // so an asynchronous reset removes them immediately.
    always_comb begin
        w_state_nxt = r_state;
        w_cs_nxt    = r_cs;
        w_hit_nxt   = r_hit;
        w_wr_nxt    = r_wr;
        w_count_nxt = r_count;
        ready       = 1'b1;
        rd_stb      = 1'b0;
        wr_stb      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    // Latch decode and direction; write wins over read.
                    // An unmatched access gets zero waits (w_wait stays 0).
                    w_state_nxt = ACCESS;
                    w_cs_nxt    = w_sel;
                    w_hit_nxt   = w_found;
                    w_wr_nxt    = wr;
                    w_count_nxt = w_wait;
                end
            end
            ACCESS: begin
                ready = (r_count == '0);
                if (r_count != '0) begin
                    w_count_nxt = r_count - WAIT_W'(1);
                end else begin
                    // Unmatched accesses still walk the FSM but never strobe.
                    rd_stb      = r_hit & ~r_wr;
                    wr_stb      = r_hit & r_wr;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!w_req) begin
                    w_state_nxt = IDLE;
                    w_cs_nxt    = '0;
                    w_hit_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cs_nxt    = '0;
                w_hit_nxt   = 1'b0;
                w_count_nxt = '0;
            end
        endcase
    end

    // State and latched-decode registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cs    <= '0;
            r_hit   <= 1'b0;
            r_wr    <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cs    <= w_cs_nxt;
            r_hit   <= w_hit_nxt;
            r_wr    <= w_wr_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign cs  = r_cs;
    assign hit = r_hit;

`ifdef UNMAPPED_ERR_EN
    logic r_err;

    // Sticky unmapped-access flag; a new unmatched access beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && w_req && !w_found) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_bus_region_decoder.sv
// tb_bus_region_decoder: directed vectors with hand-computed expectations.
module tb_bus_region_decoder;

    logic        clk;
    logic        reset;
    logic [19:0] a;
    logic        m_io;
    logic        rd;
    logic        wr;
    logic [3:0]  cs;
    logic        hit;
    logic        ready;
    logic        rd_stb;
    logic        wr_stb;
`ifdef UNMAPPED_ERR_EN
    logic        err_clr;
    logic        err;
`endif

    int errors = 0;
    int checks = 0;

    bus_region_decoder dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .m_io   (m_io),
        .rd     (rd),
        .wr     (wr),
        .cs     (cs),
        .hit    (hit),
        .ready  (ready),
        .rd_stb (rd_stb),
        .wr_stb (wr_stb)
`ifdef UNMAPPED_ERR_EN
        ,
        .err_clr(err_clr),
        .err    (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full access: request sampled at cycle 0, w wait cycles, strobe cycle,
    // 'hold' extra cycles with the request still up, then release back to IDLE.
    task automatic run_access(input string name, input logic [19:0] addr, input logic mio,
                              input logic rdi, input logic wri, input logic [3:0] ecs,
                              input int w, input int hold);
        logic ehit, erd, ewr;
        ehit = (ecs != 4'd0);
        erd  = ehit & rdi & ~wri;
        ewr  = ehit & wri;
        a = addr; m_io = mio; rd = rdi; wr = wri;
        step();
        // Address/space changes after cycle 0 must be ignored.
        a = 20'hFFFFF; m_io = ~mio;
        for (int c = 1; c <= w; c++) begin
            chk({name, "_wait_ready"}, 32'(ready), 32'(0));
            chk({name, "_wait_cs"},    32'(cs),    32'(ecs));
            chk({name, "_wait_stb"},   32'(rd_stb | wr_stb), 32'(0));
            step();
        end
        chk({name, "_ready"},  32'(ready),  32'(1));
        chk({name, "_cs"},     32'(cs),     32'(ecs));
        chk({name, "_hit"},    32'(hit),    32'(ehit));
        chk({name, "_rd_stb"}, 32'(rd_stb), 32'(erd));
        chk({name, "_wr_stb"}, 32'(wr_stb), 32'(ewr));
        for (int h = 0; h < hold; h++) begin
            step();
            chk({name, "_hold_cs"},  32'(cs),    32'(ecs));
            chk({name, "_hold_rdy"}, 32'(ready), 32'(1));
            chk({name, "_hold_stb"}, 32'(rd_stb | wr_stb), 32'(0));
        end
        rd = 1'b0; wr = 1'b0;
        if (hold == 0) begin
            step();
            chk({name, "_hold_cs"},  32'(cs), 32'(ecs));
            chk({name, "_hold_stb"}, 32'(rd_stb | wr_stb), 32'(0));
        end
        step();
        chk({name, "_idle_cs"},  32'(cs),    32'(0));
        chk({name, "_idle_hit"}, 32'(hit),   32'(0));
        chk({name, "_idle_rdy"}, 32'(ready), 32'(1));
    endtask

    initial begin
        reset = 1'b1; a = '0; m_io = 1'b1; rd = 1'b0; wr = 1'b0;
`ifdef UNMAPPED_ERR_EN
        err_clr = 1'b0;
`endif
        #1;
        chk("rst_cs",     32'(cs),     32'(0));
        chk("rst_hit",    32'(hit),    32'(0));
        chk("rst_ready",  32'(ready),  32'(1));
        chk("rst_rd_stb", 32'(rd_stb), 32'(0));
        chk("rst_wr_stb", 32'(wr_stb), 32'(0));
`ifdef UNMAPPED_ERR_EN
        chk("rst_err",    32'(err),    32'(0));
`endif
        step(); step();
        reset = 1'b0;
        step();

        // Memory read, region 1, zero waits, rd held through two HOLD cycles.
        run_access("mem_rd", 20'h10000, 1'b1, 1'b1, 1'b0, 4'b0010, 0, 2);
        // Memory write, region 3, two waits.
        run_access("mem_wr", 20'h45678, 1'b1, 1'b0, 1'b1, 4'b1000, 2, 0);
        // Same address: I/O space hits region 0, memory space hits region 1.
        run_access("io_rd",  20'h00004, 1'b0, 1'b1, 1'b0, 4'b0001, 0, 0);
        run_access("mem_lo", 20'h00004, 1'b1, 1'b1, 1'b0, 4'b0010, 0, 0);
        // Unmapped memory access.
        run_access("unmap",  20'hF0000, 1'b1, 1'b1, 1'b0, 4'b0000, 0, 0);
`ifdef UNMAPPED_ERR_EN
        chk("err_set",  32'(err), 32'(1));
        step();
        chk("err_stky", 32'(err), 32'(1));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr",  32'(err), 32'(0));
        // Set and clear on the same edge: set wins.
        a = 20'hF0000; m_io = 1'b1; rd = 1'b1; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_setwin", 32'(err), 32'(1));
        rd = 1'b0;
        step(); step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
`endif
        // Unmapped I/O access (outside region 0's window).
        run_access("io_unmap", 20'h00040, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 0);
        // rd and wr together: write wins, region 2, one wait.
        run_access("rdwr", 20'h20000, 1'b1, 1'b1, 1'b1, 4'b0100, 1, 0);

        // Request dropped during ACCESS: access still completes with its strobe.
        a = 20'h45678; m_io = 1'b1; rd = 1'b1;
        step();
        chk("drop_rdy1", 32'(ready), 32'(0));
        rd = 1'b0;
        step();
        chk("drop_rdy2", 32'(ready), 32'(0));
        step();
        chk("drop_stb",  32'(rd_stb), 32'(1));
        chk("drop_rdy3", 32'(ready),  32'(1));
        step();
        chk("drop_hold", 32'(cs),     32'(4'b1000));
        chk("drop_nstb", 32'(rd_stb), 32'(0));
        step();
        chk("drop_idle", 32'(cs),     32'(0));

        // Reset asserted mid-access (cycle 1 of a two-wait access).
        a = 20'h40000; m_io = 1'b1; rd = 1'b1;
        step();
        chk("mrst_pre_rdy", 32'(ready), 32'(0));
        chk("mrst_pre_cs",  32'(cs),    32'(4'b1000));
        #2 reset = 1'b1;
        #1;
        chk("mrst_rdy", 32'(ready), 32'(1));
        chk("mrst_cs",  32'(cs),    32'(0));
        chk("mrst_hit", 32'(hit),   32'(0));
        chk("mrst_stb", 32'(rd_stb | wr_stb), 32'(0));
        step();
        chk("mrst_stb2", 32'(rd_stb | wr_stb), 32'(0));
        rd = 1'b0;
        reset = 1'b0;
        step();
        chk("mrst_idle", 32'(cs), 32'(0));
        run_access("post_rst", 20'h40000, 1'b1, 1'b1, 1'b0, 4'b1000, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
